mem_access_ctrl: RTL

- Memory-stage controller that consumes the EX/MEM pipeline register outputs and performs the data-memory access.
- Drives a req/ack handshake to a variable-latency data memory.
- Stalls the EX/MEM register while an access is outstanding.
- Produces the registered MEM/WB stage outputs for writeback.

---
 rtl/misc_v_pkg.sv | 20 ++
 rtl/mem_wb_reg.sv | 51 +++++
 rtl/mem_access_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/misc_v_pkg.sv
// ============================================================================
// Module      : misc_v_pkg
// Description : Shared widths, defaults and state encoding for the MEM stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package misc_v_pkg;

    localparam int c_WORD_W  = 16;
    localparam int c_TIMEOUT = 15;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage : misc_v_pkg

`default_nettype wire

// File: rtl/mem_wb_reg.sv
// ============================================================================
// Module      : mem_wb_reg
// Description : MEM/WB pipeline register with load enable and bubble insert.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_reg
    import misc_v_pkg::*;
#(
    parameter int WORD_W = c_WORD_W
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_bubble,
    input  logic              i_reg_write,
    input  logic              i_reg_store,
    input  logic [WORD_W-1:0] i_alu_result,
    input  logic [WORD_W-1:0] i_mem_data,
    input  logic [WORD_W-1:0] i_rd,
    output logic              o_reg_write,
    output logic              o_reg_store,
    output logic [WORD_W-1:0] o_alu_result,
    output logic [WORD_W-1:0] o_mem_data,
    output logic [WORD_W-1:0] o_rd
);

    // A bubble only kills the control bits; the data fields keep their values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_reg_write  <= 1'b0;
            o_reg_store  <= 1'b0;
            o_alu_result <= '0;
            o_mem_data   <= '0;
            o_rd         <= '0;
        end else if (i_en) begin
            o_reg_write  <= i_reg_write;
            o_reg_store  <= i_reg_store;
            o_alu_result <= i_alu_result;
            o_mem_data   <= i_mem_data;
            o_rd         <= i_rd;
        end else if (i_bubble) begin
            o_reg_write  <= 1'b0;
            o_reg_store  <= 1'b0;
        end
    end

endmodule : mem_wb_reg

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module      : mem_access_ctrl
// Description : MEM-stage controller: req/ack data-memory access with timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl
    import misc_v_pkg::*;
#(
    parameter int WORD_W  = c_WORD_W,
    parameter int TIMEOUT = c_TIMEOUT
)(
    input  logic              CLK,
    input  logic              Reset,
    input  logic              IRegWrite,
    input  logic              IMemWrite,
    input  logic              IMemRead,
    input  logic              IRegStore,
    input  logic [WORD_W-1:0] IALUResult,
    input  logic [WORD_W-1:0] I3rdArg,
    input  logic [WORD_W-1:0] IRd,
    output logic              Stall,
    output logic              MemReq,
    output logic              MemWe,
    output logic [WORD_W-1:0] MemAddr,
    output logic [WORD_W-1:0] MemWData,
    input  logic [WORD_W-1:0] MemRData,
    input  logic              MemAck,
    output logic              ORegWrite,
    output logic              ORegStore,
    output logic [WORD_W-1:0] OALUResult,
    output logic [WORD_W-1:0] OMemData,
    output logic [WORD_W-1:0] ORd,
    output logic              OMemErr
);

    localparam int                 c_CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = '1;

    mem_state_t         r_state;
    mem_state_t         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_access;
    logic               w_timeout;
    logic               w_load;
    logic               w_bubble;
    logic [WORD_W-1:0]  w_mem_data;

    assign w_access = IMemRead | IMemWrite;

    // Ack is checked before the timeout so a late ack on the last cycle still wins.
    always_comb begin
        w_state_nxt = r_state;
        Stall       = 1'b0;
        w_load      = 1'b0;
        w_bubble    = 1'b0;
        w_timeout   = 1'b0;
        w_mem_data  = '0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    Stall       = 1'b1;
                    w_bubble    = 1'b1;
                    w_state_nxt = WAIT;
                end else begin
                    w_load = 1'b1;
                end
            end
            WAIT: begin
                if (MemAck) begin
                    w_load      = 1'b1;
                    w_mem_data  = MemWe ? '0 : MemRData;
                    w_state_nxt = IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_bubble    = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    Stall = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            MemReq   <= 1'b0;
            MemWe    <= 1'b0;
            MemAddr  <= '0;
            MemWData <= '0;
            OMemErr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_access) begin
                        MemReq   <= 1'b1;
                        MemWe    <= IMemWrite;
                        MemAddr  <= IALUResult;
                        MemWData <= I3rdArg;
                        r_cnt    <= '0;
                    end
                end
                WAIT: begin
                    if (MemAck) begin
                        MemReq <= 1'b0;
                    end else if (w_timeout) begin
                        MemReq  <= 1'b0;
                        OMemErr <= 1'b1;
                    end else if (r_cnt != c_CNT_MAX) begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    mem_wb_reg #(
        .WORD_W (WORD_W)
    ) u_mem_wb_reg (
        .clk          (CLK),
        .rst_n        (Reset),
        .i_en         (w_load),
        .i_bubble     (w_bubble),
        .i_reg_write  (IRegWrite),
        .i_reg_store  (IRegStore),
        .i_alu_result (IALUResult),
        .i_mem_data   (w_mem_data),
        .i_rd         (IRd),
        .o_reg_write  (ORegWrite),
        .o_reg_store  (ORegStore),
        .o_alu_result (OALUResult),
        .o_mem_data   (OMemData),
        .o_rd         (ORd)
    );

endmodule : mem_access_ctrl

`default_nettype wire
